// File: rtl/mem_req_sched.sv
// rtl/mem_req_sched.sv - arbitrates fetch/load/store requests onto the byte-serial memory controller
// Optional fetch anti-starvation counter enabled by MEM_SCHED_ANTISTARVE_EN.
module mem_req_sched #(
   parameter logic [31:0] IO_BASE      = 32'h30000,
   parameter int unsigned STARVE_LIMIT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        in_uart_full,
   input  logic        in_rob_misbranch,
   input  logic        in_fetcher_ce,
   input  logic [31:0] in_fetcher_addr,
   output logic        out_fetcher_ce,
   input  logic        in_lsb_ce,
   input  logic [31:0] in_lsb_addr,
   input  logic [5:0]  in_lsb_size,
   input  logic        in_lsb_signed,
   output logic        out_lsb_ce,
   input  logic        in_rob_ce,
   input  logic [31:0] in_rob_addr,
   input  logic [5:0]  in_rob_size,
   input  logic [31:0] in_rob_data,
   output logic        out_rob_ce,
   output logic [31:0] out_data,
   output logic        out_mem_ce,
   output logic        out_mem_rw,
   output logic [31:0] out_mem_addr,
   output logic [5:0]  out_mem_size,
   output logic        out_mem_signed,
   output logic [31:0] out_mem_data,
   input  logic        in_mem_done,
   input  logic [31:0] in_mem_data
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;
   typedef enum logic [1:0] {OWN_F, OWN_L, OWN_R} owner_t;

   state_t      state;
   owner_t      owner;
   logic        f_pend, l_pend, r_pend;
   logic [31:0] f_addr, l_addr, r_addr, r_data;
   logic [5:0]  l_size, r_size;
   logic        l_signed;

   // A source that is not yet latched can still win with its live inputs.
   logic [31:0] f_addr_e, l_addr_e, r_addr_e, r_data_e;
   logic [5:0]  l_size_e, r_size_e;
   logic        l_signed_e;
   assign f_addr_e   = f_pend ? f_addr   : in_fetcher_addr;
   assign l_addr_e   = l_pend ? l_addr   : in_lsb_addr;
   assign l_size_e   = l_pend ? l_size   : in_lsb_size;
   assign l_signed_e = l_pend ? l_signed : in_lsb_signed;
   assign r_addr_e   = r_pend ? r_addr   : in_rob_addr;
   assign r_size_e   = r_pend ? r_size   : in_rob_size;
   assign r_data_e   = r_pend ? r_data   : in_rob_data;

   logic mb, f_cand, l_cand, r_io, r_ok, f_starve, f_busy;
   logic can_grant, grant_r, grant_l, grant_f, done_ok, clr_f, clr_l, clr_r;
   assign mb        = in_rob_misbranch;
   assign f_cand    = (f_pend | in_fetcher_ce) & ~mb;
   assign l_cand    = (l_pend | in_lsb_ce) & ~mb;
   assign r_io      = (r_addr_e >= IO_BASE) && (r_addr_e < IO_BASE + 32'd8);
   assign r_ok      = (r_pend | in_rob_ce) & ~(in_uart_full & r_io);
   assign can_grant = (state == S_IDLE) & ~mb;
   assign grant_r   = can_grant & r_ok;
   assign grant_f   = can_grant & ~r_ok & f_cand & (f_starve | ~l_cand);
   assign grant_l   = can_grant & ~r_ok & l_cand & ~grant_f;
   assign f_busy    = (state != S_IDLE) && (owner == OWN_F);
   // A flushed fetch/load completes silently; only a ROB owner gets its done pulse.
   assign done_ok   = (state == S_WAIT) && in_mem_done && !(mb && owner != OWN_R);
   assign clr_f     = mb | (done_ok & (owner == OWN_F));
   assign clr_l     = mb | (done_ok & (owner == OWN_L));
   assign clr_r     = done_ok & (owner == OWN_R);

`ifdef MEM_SCHED_ANTISTARVE_EN
   logic [7:0] starve_cnt;
   assign f_starve = 32'(starve_cnt) >= STARVE_LIMIT;

   // Counts only while the fetch waits for a grant, not while it is in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (rdy) begin
         if (mb || grant_f)
            starve_cnt <= '0;
         else if (f_pend && !f_busy && starve_cnt != 8'hFF)
            starve_cnt <= starve_cnt + 8'd1;
      end
   end
`else
   assign f_starve = 1'b0 & (STARVE_LIMIT == 0) & f_busy;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= S_IDLE;
         owner          <= OWN_F;
         f_pend         <= 1'b0;
         l_pend         <= 1'b0;
         r_pend         <= 1'b0;
         f_addr         <= '0;
         l_addr         <= '0;
         l_size         <= '0;
         l_signed       <= 1'b0;
         r_addr         <= '0;
         r_size         <= '0;
         r_data         <= '0;
         out_fetcher_ce <= 1'b0;
         out_lsb_ce     <= 1'b0;
         out_rob_ce     <= 1'b0;
         out_data       <= '0;
         out_mem_ce     <= 1'b0;
         out_mem_rw     <= 1'b0;
         out_mem_addr   <= '0;
         out_mem_size   <= '0;
         out_mem_signed <= 1'b0;
         out_mem_data   <= '0;
      end else begin
         out_mem_ce     <= 1'b0;
         out_fetcher_ce <= 1'b0;
         out_lsb_ce     <= 1'b0;
         out_rob_ce     <= 1'b0;
         if (rdy) begin
            // Completion clears a flag before the same-cycle ce may set it again.
            f_pend <= (f_pend & ~clr_f) | (in_fetcher_ce & ~mb);
            if (in_fetcher_ce && !mb && !(f_pend && !clr_f))
               f_addr <= in_fetcher_addr;
            l_pend <= (l_pend & ~clr_l) | (in_lsb_ce & ~mb);
            if (in_lsb_ce && !mb && !(l_pend && !clr_l)) begin
               l_addr   <= in_lsb_addr;
               l_size   <= in_lsb_size;
               l_signed <= in_lsb_signed;
            end
            r_pend <= (r_pend & ~clr_r) | in_rob_ce;
            if (in_rob_ce && !(r_pend && !clr_r)) begin
               r_addr <= in_rob_addr;
               r_size <= in_rob_size;
               r_data <= in_rob_data;
            end

            case (state)
               S_IDLE: begin
                  if (grant_r || grant_l || grant_f) begin
                     out_mem_ce <= 1'b1;
                     state      <= S_WAIT;
                  end
                  if (grant_r) begin
                     owner          <= OWN_R;
                     out_mem_rw     <= 1'b1;
                     out_mem_addr   <= r_addr_e;
                     out_mem_size   <= r_size_e;
                     out_mem_signed <= 1'b0;
                     out_mem_data   <= r_data_e;
                  end else if (grant_l) begin
                     owner          <= OWN_L;
                     out_mem_rw     <= 1'b0;
                     out_mem_addr   <= l_addr_e;
                     out_mem_size   <= l_size_e;
                     out_mem_signed <= l_signed_e;
                     out_mem_data   <= '0;
                  end else if (grant_f) begin
                     owner          <= OWN_F;
                     out_mem_rw     <= 1'b0;
                     out_mem_addr   <= f_addr_e;
                     out_mem_size   <= 6'd4;
                     out_mem_signed <= 1'b0;
                     out_mem_data   <= '0;
                  end
               end
               S_WAIT: begin
                  if (mb && owner != OWN_R) begin
                     state <= in_mem_done ? S_IDLE : S_DRAIN;
                  end else if (in_mem_done) begin
                     state <= S_IDLE;
                     case (owner)
                        OWN_F:   out_fetcher_ce <= 1'b1;
                        OWN_L:   out_lsb_ce     <= 1'b1;
                        default: out_rob_ce     <= 1'b1;
                     endcase
                     if (owner != OWN_R)
                        out_data <= in_mem_data;
                  end
               end
               S_DRAIN: begin
                  if (in_mem_done)
                     state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_mem_req_sched.sv
// tb/tb_mem_req_sched.sv - self-checking bench for mem_req_sched
// Transaction-level model: pending table per source, winner chosen from the priority rules.
module tb_mem_req_sched;
   localparam logic [31:0] IO_BASE = 32'h30000;
   localparam int LIMIT = 4;
   localparam int F = 0, L = 1, R = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy = 1'b1;
   logic        in_uart_full = 1'b0, in_rob_misbranch = 1'b0;
   logic        in_fetcher_ce = 1'b0, in_lsb_ce = 1'b0, in_rob_ce = 1'b0;
   logic [31:0] in_fetcher_addr = '0, in_lsb_addr = '0, in_rob_addr = '0, in_rob_data = '0;
   logic [5:0]  in_lsb_size = '0, in_rob_size = '0;
   logic        in_lsb_signed = 1'b0;
   logic        in_mem_done = 1'b0;
   logic [31:0] in_mem_data = '0;
   logic        out_fetcher_ce, out_lsb_ce, out_rob_ce, out_mem_ce, out_mem_rw, out_mem_signed;
   logic [31:0] out_data, out_mem_addr, out_mem_data;
   logic [5:0]  out_mem_size;

   always #5 clk = ~clk;

   mem_req_sched #(.IO_BASE(IO_BASE), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .in_uart_full(in_uart_full),
      .in_rob_misbranch(in_rob_misbranch),
      .in_fetcher_ce(in_fetcher_ce), .in_fetcher_addr(in_fetcher_addr), .out_fetcher_ce(out_fetcher_ce),
      .in_lsb_ce(in_lsb_ce), .in_lsb_addr(in_lsb_addr), .in_lsb_size(in_lsb_size),
      .in_lsb_signed(in_lsb_signed), .out_lsb_ce(out_lsb_ce),
      .in_rob_ce(in_rob_ce), .in_rob_addr(in_rob_addr), .in_rob_size(in_rob_size),
      .in_rob_data(in_rob_data), .out_rob_ce(out_rob_ce),
      .out_data(out_data), .out_mem_ce(out_mem_ce), .out_mem_rw(out_mem_rw),
      .out_mem_addr(out_mem_addr), .out_mem_size(out_mem_size), .out_mem_signed(out_mem_signed),
      .out_mem_data(out_mem_data), .in_mem_done(in_mem_done), .in_mem_data(in_mem_data)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   bit          m_pend [3];
   logic [31:0] m_addr [3];
   logic [5:0]  m_size [3];
   bit          m_sgn  [3];
   logic [31:0] m_data [3];
   int          m_since[3];
   int          m_owner = -1;
   logic [31:0] m_out_data = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      in_fetcher_ce    = 1'b0;
      in_lsb_ce        = 1'b0;
      in_rob_ce        = 1'b0;
      in_mem_done      = 1'b0;
      in_rob_misbranch = 1'b0;
   endtask

   function automatic logic [5:0] rsize();
      int k;
      k = int'($urandom_range(0, 2));
      return (k == 0) ? 6'd1 : (k == 1) ? 6'd2 : 6'd4;
   endfunction

   task automatic req_f(input logic [31:0] a);
      in_fetcher_ce = 1'b1; in_fetcher_addr = a;
      if (!m_pend[F]) begin m_pend[F] = 1; m_addr[F] = a; m_since[F] = cyc; end
   endtask

   task automatic req_l(input logic [31:0] a, input logic [5:0] sz, input bit sg);
      in_lsb_ce = 1'b1; in_lsb_addr = a; in_lsb_size = sz; in_lsb_signed = sg;
      if (!m_pend[L]) begin m_pend[L] = 1; m_addr[L] = a; m_size[L] = sz; m_sgn[L] = sg; m_since[L] = cyc; end
   endtask

   task automatic req_r(input logic [31:0] a, input logic [5:0] sz, input logic [31:0] d);
      in_rob_ce = 1'b1; in_rob_addr = a; in_rob_size = sz; in_rob_data = d;
      if (!m_pend[R]) begin m_pend[R] = 1; m_addr[R] = a; m_size[R] = sz; m_data[R] = d; m_since[R] = cyc; end
   endtask

   // Winner for a decision taken in cycle d, from the model's pending table.
   function automatic int exp_winner(input int d);
      bit r_ok, starve;
      r_ok = m_pend[R] && !(in_uart_full && m_addr[R] >= IO_BASE && m_addr[R] < IO_BASE + 8);
      starve = 1'b0;
`ifdef MEM_SCHED_ANTISTARVE_EN
      starve = m_pend[F] && (d - m_since[F] - 1 >= LIMIT);
`endif
      if (r_ok) return R;
      if (m_pend[F] && (starve || !m_pend[L])) return F;
      if (m_pend[L]) return L;
      return -1;
   endfunction

   task automatic expect_issue(input string tag, input int exp_cyc);
      int t0, w;
      t0 = cyc;
      while (out_mem_ce !== 1'b1 && cyc - t0 < 40) tick();
      chk({tag, "_seen"}, 32'(out_mem_ce), 32'd1);
      if (exp_cyc >= 0) chk({tag, "_cycle"}, 32'(cyc), 32'(exp_cyc));
      w = exp_winner(cyc - 1);
      chk({tag, "_has_winner"}, 32'(w >= 0), 32'd1);
      if (w >= 0) begin
         m_owner = w;
         chk({tag, "_rw"},   32'(out_mem_rw), 32'(w == R));
         chk({tag, "_addr"}, out_mem_addr, m_addr[w]);
         chk({tag, "_size"}, 32'(out_mem_size), (w == F) ? 32'd4 : 32'(m_size[w]));
         chk({tag, "_sgn"},  32'(out_mem_signed), (w == L) ? 32'(m_sgn[L]) : 32'd0);
         chk({tag, "_wdata"}, out_mem_data, (w == R) ? m_data[R] : 32'd0);
      end
   endtask

   task automatic expect_no_issue(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         chk(tag, 32'(out_mem_ce), 32'd0);
      end
   endtask

   task automatic complete(input string tag, input logic [31:0] d, input int delay, input bit relsb);
      int w;
      repeat (delay) tick();
      in_mem_done = 1'b1;
      in_mem_data = d;
      w = m_owner;
      if (w >= 0) m_pend[w] = 0;
      if (w == F || w == L) m_out_data = d;
      if (relsb) req_l(32'h0001_0000 + 32'($urandom_range(0, 255) * 4), rsize(), 1'($urandom_range(0, 1)));
      tick();
      chk({tag, "_fdone"}, 32'(out_fetcher_ce), 32'(w == F));
      chk({tag, "_ldone"}, 32'(out_lsb_ce), 32'(w == L));
      chk({tag, "_rdone"}, 32'(out_rob_ce), 32'(w == R));
      chk({tag, "_data"}, out_data, m_out_data);
      m_owner = -1;
   endtask

   task automatic drain(input string tag);
      int guard;
      guard = 0;
      while ((m_pend[F] || m_pend[L] || m_pend[R]) && guard < 4) begin
         expect_issue(tag, cyc + 1);
         complete(tag, $urandom, int'($urandom_range(0, 4)), 1'b0);
         guard++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cycle=%0d expected=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int got_f, nl, mask;
      logic [31:0] bnd [2];

      // Reset state
      tick(); tick();
      chk("rst_fdone", 32'(out_fetcher_ce), 0);
      chk("rst_ldone", 32'(out_lsb_ce), 0);
      chk("rst_rdone", 32'(out_rob_ce), 0);
      chk("rst_data", out_data, 0);
      chk("rst_mce", 32'(out_mem_ce), 0);
      chk("rst_addr", out_mem_addr, 0);
      chk("rst_size", 32'(out_mem_size), 0);
      rst = 1'b1;
      tick();

      // Fetch: ce in cycle c0, issue c0+1, done c0+6, return c0+7
      begin
         int c0;
         c0 = cyc;
         req_f(32'h1000);
         tick();
         expect_issue("fetch", c0 + 1);
         complete("fetch", 32'h00C58593, 5, 1'b0);
         chk("fetch_ret_cycle", 32'(cyc), 32'(c0 + 7));
      end

      // Priority with simultaneous requests; a repeated LSB ce while pending is ignored
      req_f(32'h1000 + 32'($urandom_range(0, 255) * 4));
      req_l(32'h20, 6'd4, 1'($urandom_range(0, 1)));
      req_r(32'h40, 6'd4, 32'hDEADBEEF);
      tick();
      expect_issue("prio1", cyc);
      req_l(32'h999, 6'd1, 1'b1);
      complete("prio1", $urandom, int'($urandom_range(1, 5)), 1'b0);
      expect_issue("prio2", cyc + 1);
      complete("prio2", $urandom, int'($urandom_range(0, 5)), 1'b0);
      expect_issue("prio3", cyc + 1);
      complete("prio3", $urandom, int'($urandom_range(0, 5)), 1'b0);
      expect_no_issue("prio_quiet", 2);

      // UART gate on the I/O window
      in_uart_full = 1'b1;
      req_r(IO_BASE + 32'($urandom_range(0, 7)), 6'd1, $urandom);
      req_l(32'h0001_0200, 6'd4, 1'b0);
      tick();
      expect_issue("uart_l", cyc);
      complete("uart_l", $urandom, 2, 1'b0);
      expect_no_issue("uart_hold", 3);
      in_uart_full = 1'b0;
      tick();
      expect_issue("uart_r", cyc);
      complete("uart_r", 32'h0, 1, 1'b0);

      // Addresses just outside the window are never gated
      bnd[0] = IO_BASE + 32'd8;
      bnd[1] = IO_BASE - 32'd1;
      for (int i = 0; i < 2; i++) begin
         in_uart_full = 1'b1;
         req_r(bnd[i], 6'd2, $urandom);
         tick();
         expect_issue("uart_edge", cyc);
         complete("uart_edge", 32'h0, 0, 1'b0);
         in_uart_full = 1'b0;
      end

      // Flush during a fetch WAIT; the pending store still issues
      req_f(32'h2000);
      tick();
      expect_issue("flush_f", cyc);
      tick();
      req_r(32'h0002_0100, 6'd4, $urandom);
      tick();
      in_rob_misbranch = 1'b1;
      in_lsb_ce = 1'b1;
      in_lsb_addr = 32'h0001_0F00;
      m_pend[F] = 0;
      m_pend[L] = 0;
      tick();
      tick();
      in_mem_done = 1'b1;
      in_mem_data = 32'hBAD0_BAD0;
      tick();
      chk("flush_no_fdone", 32'(out_fetcher_ce), 0);
      chk("flush_data_kept", out_data, m_out_data);
      expect_issue("flush_rob", cyc + 1);
      complete("flush_rob", 32'h0, 1, 1'b0);
      expect_no_issue("flush_quiet", 4);

      // rdy low: no sampling, no completion, pulses low
      req_f(32'h3000);
      tick();
      expect_issue("rdy_f", cyc);
      rdy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_lsb_ce = 1'b1;
         in_lsb_addr = 32'h0001_0300;
         in_mem_done = 1'b1;
         in_mem_data = 32'h1111_2222;
         tick();
         chk("rdy_hold_fdone", 32'(out_fetcher_ce), 0);
         chk("rdy_hold_mce", 32'(out_mem_ce), 0);
      end
      rdy = 1'b1;
      complete("rdy_f", 32'h3333_4444, 0, 1'b0);
      expect_no_issue("rdy_quiet", 3);

      // Asynchronous reset mid-WAIT
      req_l(32'h0001_0040, 6'd2, 1'b1);
      tick();
      expect_issue("rst_l", cyc);
      tick();
      #2 rst = 1'b0;
      #1;
      chk("arst_addr", out_mem_addr, 0);
      chk("arst_size", 32'(out_mem_size), 0);
      chk("arst_sgn", 32'(out_mem_signed), 0);
      chk("arst_data", out_data, 0);
      for (int i = 0; i < 3; i++) m_pend[i] = 0;
      m_owner = -1;
      m_out_data = '0;
      tick();
      rst = 1'b1;
      in_mem_done = 1'b1;
      in_mem_data = 32'hCAFE_F00D;
      tick();
      chk("arst_no_ldone", 32'(out_lsb_ce), 0);
      chk("arst_data_after", out_data, 0);
      expect_no_issue("arst_quiet", 4);

      // Randomized request mixes
      for (int it = 0; it < 16; it++) begin
         mask = int'($urandom_range(1, 7));
         if (mask[0]) req_f(32'h1000 + 32'($urandom_range(0, 255) * 4));
         if (mask[1]) req_l(32'h0001_0000 + 32'($urandom_range(0, 1023)), rsize(), 1'($urandom_range(0, 1)));
         if (mask[2]) req_r(32'h0002_0000 + 32'($urandom_range(0, 1023)), rsize(), $urandom);
         tick();
         expect_issue("rnd_first", cyc);
         complete("rnd_first", $urandom, int'($urandom_range(0, 4)), 1'b0);
         drain("rnd");
      end

`ifdef MEM_SCHED_ANTISTARVE_EN
      // Continuous LSB traffic: fetch wins once its wait count reaches the limit
      req_f(32'h4000);
      req_l(32'h0001_0500, 6'd4, 1'b0);
      tick();
      expect_issue("starve", cyc);
      got_f = 0;
      nl = 0;
      for (int k = 0; k < 12 && got_f == 0; k++) begin
         if (m_owner == F) begin
            got_f = 1;
            complete("starve_f", $urandom, 1, 1'b0);
         end else begin
            nl++;
            complete("starve_l", $urandom, 1, 1'b1);
            expect_issue("starve", cyc + 1);
         end
      end
      chk("starve_granted", 32'(got_f), 1);
      chk("starve_lsb_before", 32'(nl), 2);
      drain("starve_drain");
`else
      got_f = 0;
      nl = 0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
